// File: rtl/divider_iterative.sv
// Iterative unsigned divider: restoring shift-subtract, one quotient bit per clock.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake; dividend/divisor sampled on accept
//   out_valid/out_ready result handshake; result held until taken
//   quotient, remainder unsigned result (quotient is all ones for a zero divisor)
//   div_by_zero         result came from a zero divisor
module divider_iterative #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;

    // The partial remainder is always below the divisor, so the shifted value is below
    // 2*divisor. A WIDTH+1-bit difference is then exact when non-negative, and its MSB
    // is set exactly when the subtraction borrowed.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    dvs_d = divisor;
                    if (divisor == '0) begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        // Dividend sits in the quotient register and shifts out MSB-first.
                        quo_d   = dividend;
                        rem_d   = '0;
                        dbz_d   = 1'b0;
                        cnt_d   = CntLast;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = (state_q == StDone);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_iterative.sv
// Directed and random checks for divider_iterative (WIDTH = 32).
module tb_divider_iterative;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int n_vec;
    int n_err;

    divider_iterative #(.WIDTH(WIDTH)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Accept a/b, check latency (edges after the accept edge) and result, hold the result
    // for 'stall' cycles while scribbling on the inputs, then hand it off.
    task automatic run_div(input string tag, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input int stall);
        logic [WIDTH-1:0] exp_q;
        logic [WIDTH-1:0] exp_r;
        int               edges;
        exp_q = (b == 0) ? {WIDTH{1'b1}} : a / b;
        exp_r = (b == 0) ? a : a % b;

        @(posedge clk);
        #1;
        check_eq({tag, " in_ready"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        dividend  = a;
        divisor   = b;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        edges    = 0;
        while (!out_valid && edges < WIDTH + 8) begin
            @(posedge clk);
            #1;
            edges++;
        end
        // A zero divisor resolves on the accept edge itself.
        check_eq({tag, " latency"}, 64'(edges), (b == 0) ? 64'd0 : 64'(WIDTH));
        check_eq({tag, " quotient"}, 64'(quotient), 64'(exp_q));
        check_eq({tag, " remainder"}, 64'(remainder), 64'(exp_r));
        check_eq({tag, " div_by_zero"}, 64'(div_by_zero), 64'(b == 0));
        if (b != 0) begin
            check_eq({tag, " invariant"}, 64'(quotient) * 64'(b) + 64'(remainder), 64'(a));
            check_eq({tag, " rem<div"}, 64'(remainder < b), 64'd1);
        end

        for (int i = 0; i < stall; i++) begin
            in_valid = ~in_valid;
            dividend = $urandom;
            divisor  = $urandom;
            @(posedge clk);
            #1;
            check_eq({tag, " hold valid"}, 64'(out_valid), 64'd1);
            check_eq({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
            check_eq({tag, " hold quotient"}, 64'(quotient), 64'(exp_q));
            check_eq({tag, " hold remainder"}, 64'(remainder), 64'(exp_r));
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, " handoff valid"}, 64'(out_valid), 64'd0);
        check_eq({tag, " handoff in_ready"}, 64'(in_ready), 64'd1);
        check_eq({tag, " after quotient"}, 64'(quotient), 64'(exp_q));
        check_eq({tag, " after dbz"}, 64'(div_by_zero), 64'(b == 0));
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset out_valid", 64'(out_valid), 64'd0);
        check_eq("reset quotient", 64'(quotient), 64'd0);
        check_eq("reset remainder", 64'(remainder), 64'd0);
        check_eq("reset dbz", 64'(div_by_zero), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("reset in_ready", 64'(in_ready), 64'd1);

        run_div("100/7", 32'd100, 32'd7, 0);
        run_div("div0", 32'h0000_1234, 32'd0, 0);
        run_div("9/3", 32'd9, 32'd3, 0);
        run_div("max/1", 32'hFFFF_FFFF, 32'd1, 0);
        run_div("5/10", 32'd5, 32'd10, 0);
        run_div("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_div("backpressure", 32'd1000, 32'd33, 10);

        // Reset during the 15th BUSY cycle.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd33;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst quotient", 64'(quotient), 64'd0);
        check_eq("midrst remainder", 64'(remainder), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("midrst in_ready", 64'(in_ready), 64'd1);
        run_div("post-reset 100/7", 32'd100, 32'd7, 0);

        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = 32'($urandom_range(1, 255));
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 9) == 0) rb = '0;
            run_div($sformatf("rand%0d", i), ra, rb, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
